// File: rtl/control_mem_vec_if.sv
// Handshake/bus bundle between the EX/MEM requester and the MEM-stage sequencer.
// The master side issues memory instructions; the slave side walks the elements.
interface control_mem_vec_if #(
  parameter int CNT_W = 32
);
  logic             start;
  logic [1:0]       op;
  logic [7:0]       inmediate_in;
  logic [CNT_W-1:0] final_mem;
  logic             src_sel;
  logic [31:0]      dir_mem;
  logic             mem_wr;
  logic             sel_data;
  logic             stall;
  logic             wb_valid;
  logic [CNT_W-1:0] wb_idx;
  logic             done;

  modport master (
    output start, op, inmediate_in, final_mem, src_sel,
    input  dir_mem, mem_wr, sel_data, stall, wb_valid, wb_idx, done
  );

  modport slave (
    input  start, op, inmediate_in, final_mem, src_sel,
    output dir_mem, mem_wr, sel_data, stall, wb_valid, wb_idx, done
  );
endinterface

// File: rtl/control_mem_vec.sv
// MEM-stage sequencer: walks element addresses for scalar/vector loads and stores,
// tags registered load returns with their element index and stalls upstream.
module control_mem_vec #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  control_mem_vec_if.slave bus
);

  if (ADDR_W > 32) begin : g_addr_w_check
    $error("ADDR_W must not exceed the 32-bit dir_mem width");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t           state_r;
  logic             is_store_r;
  logic [7:0]       base_r;
  logic [CNT_W-1:0] end_r;
  logic [CNT_W-1:0] idx_r;
  logic [31:0]      dir_mem_r;
  logic             mem_wr_r;
  logic             sel_data_r;
  logic             stall_r;
  logic             wb_valid_r;
  logic [CNT_W-1:0] wb_idx_r;
  logic             done_r;

  // Full 32-bit sum; the RAM itself only decodes the low ADDR_W bits, so it wraps there.
  function automatic logic [31:0] elem_addr(input logic [7:0] base, input logic [CNT_W-1:0] idx);
    return {24'd0, base} + 32'(idx);
  endfunction

  // Sequencer state and all registered outputs, updated together so outputs track state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      is_store_r <= 1'b0;
      base_r     <= 8'd0;
      end_r      <= '0;
      idx_r      <= '0;
      dir_mem_r  <= 32'd0;
      mem_wr_r   <= 1'b0;
      sel_data_r <= 1'b0;
      stall_r    <= 1'b0;
      wb_valid_r <= 1'b0;
      wb_idx_r   <= '0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ACCESS: begin
          // Registered RAM read: this cycle's load element shows up next cycle.
          wb_valid_r <= ~is_store_r;
          wb_idx_r   <= is_store_r ? '0 : idx_r;
          if (idx_r == end_r) begin
            state_r    <= DRAIN;
            dir_mem_r  <= 32'd0;
            mem_wr_r   <= 1'b0;
            sel_data_r <= 1'b0;
            stall_r    <= 1'b0;
            done_r     <= 1'b1;
          end else begin
            idx_r     <= idx_r + CNT_W'(1);
            dir_mem_r <= elem_addr(base_r, idx_r + CNT_W'(1));
          end
        end
        IDLE, DRAIN: begin
          wb_valid_r <= 1'b0;
          wb_idx_r   <= '0;
          idx_r      <= '0;
          if (bus.start) begin
            state_r    <= ACCESS;
            is_store_r <= bus.op[0];
            base_r     <= bus.inmediate_in;
            end_r      <= bus.op[1] ? bus.final_mem : '0;
            dir_mem_r  <= {24'd0, bus.inmediate_in};
            mem_wr_r   <= bus.op[0];
            sel_data_r <= bus.src_sel;
            stall_r    <= 1'b1;
          end else begin
            state_r    <= IDLE;
            dir_mem_r  <= 32'd0;
            mem_wr_r   <= 1'b0;
            sel_data_r <= 1'b0;
            stall_r    <= 1'b0;
          end
        end
        default: begin
          state_r    <= IDLE;
          idx_r      <= '0;
          dir_mem_r  <= 32'd0;
          mem_wr_r   <= 1'b0;
          sel_data_r <= 1'b0;
          stall_r    <= 1'b0;
          wb_valid_r <= 1'b0;
          wb_idx_r   <= '0;
        end
      endcase
    end
  end

  assign bus.dir_mem  = dir_mem_r;
  assign bus.mem_wr   = mem_wr_r;
  assign bus.sel_data = sel_data_r;
  assign bus.stall    = stall_r;
  assign bus.wb_valid = wb_valid_r;
  assign bus.wb_idx   = wb_idx_r;
  assign bus.done     = done_r;

endmodule

// File: tb/tb_control_mem_vec.sv
// Directed bench for control_mem_vec with a 256x8 registered-read RAM model.
module tb_control_mem_vec;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  control_mem_vec_if #(.CNT_W(CNT_W)) bus ();

  control_mem_vec #(.ADDR_W(8), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] ram [256];
  logic [7:0] q;
  logic [7:0] data1_in;
  logic [7:0] result_alu;
  logic [7:0] wdata;
  logic       ram_loaded = 1'b0;

  assign data1_in   = bus.dir_mem[7:0] ^ 8'h3C;
  assign result_alu = bus.dir_mem[7:0] ^ 8'h5A;
  assign wdata      = bus.sel_data ? result_alu : data1_in;

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
      ram[8'h20] <= 8'hA0;
      ram[8'h21] <= 8'hA1;
      ram[8'h22] <= 8'hA2;
      ram[8'h23] <= 8'hA3;
      ram[8'h05] <= 8'h77;
      ram_loaded <= 1'b1;
    end else begin
      if (bus.mem_wr) ram[bus.dir_mem[7:0]] <= wdata;
      q <= ram[bus.dir_mem[7:0]];
    end
  end

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] imm, input logic [31:0] fin,
                       input logic sel);
    bus.op           = op;
    bus.inmediate_in = imm;
    bus.final_mem    = fin;
    bus.src_sel      = sel;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.wb_idx, bus.dir_mem[26:0], bus.mem_wr, bus.sel_data, bus.stall,
            bus.wb_valid, bus.done};
  endfunction

  logic [31:0] exp_dir [4] = '{32'h0000_00FE, 32'h0000_00FF, 32'h0000_0100, 32'h0000_0101};
  logic [7:0]  exp_wr  [4] = '{8'hC2, 8'hC3, 8'h3C, 8'h3D};
  logic [7:0]  wr_addr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    int done_cnt;
    reset            = 1'b1;
    bus.start        = 1'b0;
    bus.op           = 2'b00;
    bus.inmediate_in = 8'h00;
    bus.final_mem    = 32'd0;
    bus.src_sel      = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset, then reset pulse while idle
    for (int c = 0; c < 5; c++) begin
      tick();
      check_val($sformatf("idle_outs_c%0d", c), all_outs(), 64'd0);
    end
    check_val("idle_dir_hi", {32'd0, bus.dir_mem}, 64'd0);
    reset = 1'b1;
    #1;
    check_val("idle_reset_outs", all_outs(), 64'd0);
    tick();
    reset = 1'b0;
    tick();
    check_val("idle_after_reset", all_outs(), 64'd0);

    // Scalar store from result_alu at 0x10
    issue(2'b01, 8'h10, 32'd7, 1'b1);
    check_val("ss_dir", bus.dir_mem, 32'h10);
    check_val("ss_wr", bus.mem_wr, 1'b1);
    check_val("ss_sel", bus.sel_data, 1'b1);
    check_val("ss_stall", bus.stall, 1'b1);
    check_val("ss_done_c1", bus.done, 1'b0);
    tick();
    check_val("ss_done_c2", bus.done, 1'b1);
    check_val("ss_stall_c2", bus.stall, 1'b0);
    check_val("ss_wr_c2", bus.mem_wr, 1'b0);
    check_val("ss_wbv_c2", bus.wb_valid, 1'b0);
    tick();
    check_val("ss_done_c3", bus.done, 1'b0);
    check_val("ss_ram", ram[8'h10], 8'h4A);

    // Vector load of four elements from 0x20
    issue(2'b10, 8'h20, 32'd3, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      check_val($sformatf("vl_dir_c%0d", c), bus.dir_mem, (c <= 4) ? 32'h20 + 32'(c - 1) : 32'd0);
      check_val($sformatf("vl_stall_c%0d", c), bus.stall, (c <= 4) ? 1'b1 : 1'b0);
      check_val($sformatf("vl_wr_c%0d", c), bus.mem_wr, 1'b0);
      check_val($sformatf("vl_wbv_c%0d", c), bus.wb_valid, (c >= 2) ? 1'b1 : 1'b0);
      check_val($sformatf("vl_done_c%0d", c), bus.done, (c == 5) ? 1'b1 : 1'b0);
      if (c >= 2) begin
        check_val($sformatf("vl_idx_c%0d", c), bus.wb_idx, 32'(c - 2));
        check_val($sformatf("vl_q_c%0d", c), q, 8'hA0 + 8'(c - 2));
      end
      if (c < 5) tick();
    end
    tick();
    check_val("vl_idle", all_outs(), 64'd0);

    // Vector store wrapping past the top of the RAM
    issue(2'b11, 8'hFE, 32'd3, 1'b0);
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("vs_dir_e%0d", c), bus.dir_mem, exp_dir[c]);
      check_val($sformatf("vs_wr_e%0d", c), bus.mem_wr, 1'b1);
      check_val($sformatf("vs_wbv_e%0d", c), bus.wb_valid, 1'b0);
      tick();
    end
    check_val("vs_done", bus.done, 1'b1);
    check_val("vs_wr_drain", bus.mem_wr, 1'b0);
    check_val("vs_wbv_drain", bus.wb_valid, 1'b0);
    tick();
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("vs_ram_%0h", wr_addr[c]), ram[wr_addr[c]], exp_wr[c]);
    end

    // Back-to-back: two-element store, then scalar load accepted in DRAIN
    issue(2'b11, 8'h40, 32'd1, 1'b1);
    check_val("bb_dir_c1", bus.dir_mem, 32'h40);
    tick();
    check_val("bb_dir_c2", bus.dir_mem, 32'h41);
    check_val("bb_done_c2", bus.done, 1'b0);
    tick();
    check_val("bb_done_c3", bus.done, 1'b1);
    check_val("bb_stall_c3", bus.stall, 1'b0);
    bus.op           = 2'b00;
    bus.inmediate_in = 8'h05;
    bus.final_mem    = 32'd9;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    check_val("bb_dir_c4", bus.dir_mem, 32'h05);
    check_val("bb_stall_c4", bus.stall, 1'b1);
    check_val("bb_wr_c4", bus.mem_wr, 1'b0);
    check_val("bb_done_c4", bus.done, 1'b0);
    tick();
    check_val("bb_wbv_c5", bus.wb_valid, 1'b1);
    check_val("bb_idx_c5", bus.wb_idx, 32'd0);
    check_val("bb_q_c5", q, 8'h77);
    check_val("bb_done_c5", bus.done, 1'b1);
    check_val("bb_ram_40", ram[8'h40], 8'h1A);
    check_val("bb_ram_41", ram[8'h41], 8'h1B);
    tick();

    // Reset in the middle of an eight-element load
    issue(2'b10, 8'h30, 32'd7, 1'b0);
    check_val("rm_stall_c1", bus.stall, 1'b1);
    tick();
    check_val("rm_wbv_c2", bus.wb_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_val("rm_async_outs", all_outs(), 64'd0);
    tick();
    reset    = 1'b0;
    done_cnt = 0;
    repeat (10) begin
      tick();
      done_cnt += int'(bus.done) + int'(bus.stall) + int'(bus.wb_valid);
    end
    check_val("rm_no_activity", 64'(done_cnt), 64'd0);
    issue(2'b00, 8'h21, 32'd0, 1'b0);
    check_val("rm_new_dir", bus.dir_mem, 32'h21);
    check_val("rm_new_stall", bus.stall, 1'b1);
    tick();
    check_val("rm_new_wbv", bus.wb_valid, 1'b1);
    check_val("rm_new_q", q, 8'hA1);
    check_val("rm_new_done", bus.done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
